// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : XLEN-wide execute ALU with valid/ready handshakes, single-cycle
//            integer ops and an iterative shift-add unsigned multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal_op,
  output logic            busy
);

  localparam int              c_shw  = $clog2(XLEN);
  localparam logic [c_shw-1:0] c_last = c_shw'(XLEN - 1);

  localparam logic [3:0] c_op_add   = 4'd0;
  localparam logic [3:0] c_op_sub   = 4'd1;
  localparam logic [3:0] c_op_xor   = 4'd2;
  localparam logic [3:0] c_op_or    = 4'd3;
  localparam logic [3:0] c_op_and   = 4'd4;
  localparam logic [3:0] c_op_sll   = 4'd5;
  localparam logic [3:0] c_op_srl   = 4'd6;
  localparam logic [3:0] c_op_sra   = 4'd7;
  localparam logic [3:0] c_op_slt   = 4'd8;
  localparam logic [3:0] c_op_sltu  = 4'd9;
  localparam logic [3:0] c_op_mul   = 4'd10;
  localparam logic [3:0] c_op_mulhu = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_illegal;
  logic [XLEN-1:0]   w_fast_result;
  logic [c_shw-1:0]  w_shamt;
  logic [XLEN-1:0]   r_result;
  logic              r_illegal;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic              r_mulhu;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] w_acc_next;
  logic [c_shw-1:0]  r_count;

  assign in_ready   = (r_state == S_IDLE) | ((r_state == S_HOLD) & out_ready);
  assign w_accept   = in_valid & in_ready;
  assign w_is_mul   = MUL_EN && ((op == c_op_mul) || (op == c_op_mulhu));
  assign w_shamt    = operand_b[c_shw-1:0];
  assign result     = r_result;
  assign illegal_op = r_illegal;

  always_comb begin
    w_fast_result = '0;
    w_illegal     = 1'b0;
    case (op)
      c_op_add:   w_fast_result = operand_a + operand_b;
      c_op_sub:   w_fast_result = operand_a - operand_b;
      c_op_xor:   w_fast_result = operand_a ^ operand_b;
      c_op_or:    w_fast_result = operand_a | operand_b;
      c_op_and:   w_fast_result = operand_a & operand_b;
      c_op_sll:   w_fast_result = operand_a << w_shamt;
      c_op_srl:   w_fast_result = operand_a >> w_shamt;
      c_op_sra:   w_fast_result = $unsigned($signed(operand_a) >>> w_shamt);
      c_op_slt:   w_fast_result = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      c_op_sltu:  w_fast_result = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
      // Multiply opcodes only reach this path as illegal when the engine is absent
      c_op_mul,
      c_op_mulhu: w_illegal     = ~MUL_EN;
      default:    w_illegal     = 1'b1;
    endcase
  end

  generate
    if (MUL_EN) begin : g_mul
      logic [2*XLEN-1:0] w_addend;
      assign w_addend   = {{XLEN{1'b0}}, r_a} << r_count;
      assign w_acc_next = r_b[r_count] ? (r_acc + w_addend) : r_acc;
    end else begin : g_no_mul
      assign w_acc_next = r_acc;
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_is_mul ? S_MUL : S_HOLD;
      end
      S_MUL: begin
        busy = 1'b1;
        if (r_count == c_last) w_state_next = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (w_accept)       w_state_next = w_is_mul ? S_MUL : S_HOLD;
        else if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_illegal <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_mulhu   <= 1'b0;
      r_acc     <= '0;
      r_count   <= '0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_a     <= operand_a;
        r_b     <= operand_b;
        r_mulhu <= op[0];
        r_acc   <= '0;
        r_count <= '0;
      end else begin
        r_result  <= w_fast_result;
        r_illegal <= w_illegal;
      end
    end else if (r_state == S_MUL) begin
      r_acc   <= w_acc_next;
      r_count <= r_count + c_shw'(1);
      // Final step: publish straight from the updated accumulator
      if (r_count == c_last) begin
        r_result  <= r_mulhu ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
        r_illegal <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Directed scoreboard bench for alu_exec_unit (MUL_EN=1 and 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  typedef struct packed {
    logic [31:0] res;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, illegal_op, busy;
  logic [3:0]  op;
  logic [31:0] operand_a, operand_b, result;

  logic        in_valid_0, in_ready_0, out_valid_0, out_ready_0, illegal_op_0, busy_0;
  logic [3:0]  op_0;
  logic [31:0] operand_a_0, operand_b_0, result_0;

  int   checks = 0;
  int   errors = 0;
  bit   busy0_seen = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .illegal_op(illegal_op), .busy(busy)
  );

  alu_exec_unit #(.XLEN(32), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_0), .in_ready(in_ready_0), .op(op_0),
    .operand_a(operand_a_0), .operand_b(operand_b_0), .out_valid(out_valid_0),
    .out_ready(out_ready_0), .result(result_0), .illegal_op(illegal_op_0), .busy(busy_0)
  );

  always @(negedge clk) if (busy_0 === 1'b1) busy0_seen = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an op, wait (bounded) for acceptance, record the expected output.
  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ei);
    int n = 0;
    op = o; operand_a = a; operand_b = b; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    check("accept_wait", (n < 100), 1'b1);
    sb.push_back('{res: er, ill: ei});
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); operand_a = $urandom; operand_b = $urandom;
  endtask

  task automatic wait_out(input string tag, input int start, input int exp_lat);
    int   lat = start;
    exp_t e;
    while (out_valid !== 1'b1 && lat < exp_lat + 40) begin @(posedge clk); #1; lat++; end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, result, e.res);
      check({tag, "_illegal"}, illegal_op, e.ill);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_fast(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ei);
    drive(o, a, b, er, ei);
    wait_out(tag, 1, 1);
    consume();
  endtask

  task automatic run_mul(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er);
    bit good = 1'b1;
    drive(o, a, b, er, 1'b0);
    repeat (32) begin
      good &= (busy === 1'b1) && (in_ready === 1'b0) && (out_valid === 1'b0);
      @(posedge clk); #1;
    end
    check({tag, "_busy_window"}, good, 1'b1);
    wait_out(tag, 33, 33);
    check({tag, "_busy_after"}, busy, 1'b0);
    consume();
  endtask

  initial begin
    bit good;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    in_valid_0 = 1'b0; out_ready_0 = 1'b0; op_0 = '0; operand_a_0 = '0; operand_b_0 = '0;

    // Reset with random activity on the inputs
    repeat (4) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); op = 4'($urandom); out_ready = 1'($urandom);
      operand_a = $urandom; operand_b = $urandom;
    end
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_illegal", illegal_op, 1'b0);
    check("rst_busy", busy, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_idle_out_valid", out_valid, 1'b0);

    // Fast arithmetic
    run_fast("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    run_fast("sub_wrap", 4'd1, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0);
    run_fast("sra",      4'd7, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0);
    run_fast("slt",      4'd8, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
    run_fast("sltu",     4'd9, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    run_fast("xor",      4'd2, 32'hA5A5_0F0F, 32'hFFFF_0000, 32'h5A5A_0F0F, 1'b0);
    run_fast("or",       4'd3, 32'h1200_0034, 32'h0056_7800, 32'h1256_7834, 1'b0);
    run_fast("and",      4'd4, 32'hF0F0_FFFF, 32'h0FF0_1234, 32'h00F0_1234, 1'b0);
    run_fast("sll",      4'd5, 32'h1, 32'h3F, 32'h8000_0000, 1'b0);
    run_fast("srl",      4'd6, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0);
    check("idle_after_consume", out_valid, 1'b0);

    // Illegal opcode
    run_fast("illegal13", 4'd13, 32'h1234, 32'h5678, 32'h0, 1'b1);

    // Multiply
    run_mul("mul",   4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_mul("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mul("mul_small", 4'd10, 32'd12345, 32'd6789, 32'd83810205);

    // Backpressure then handoff without a bubble
    drive(4'd0, 32'd5, 32'd7, 32'd12, 1'b0);
    wait_out("bp_add", 1, 1);
    good = 1'b1;
    repeat (3) begin
      good &= (out_valid === 1'b1) && (result === 32'd12) && (in_ready === 1'b0) &&
              (illegal_op === 1'b0);
      @(posedge clk); #1;
    end
    check("bp_hold_stable", good, 1'b1);
    out_ready = 1'b1;
    drive(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0);
    wait_out("bp_xor", 1, 1);

    // Back-to-back fast ops with the consumer always ready
    drive(4'd0, 32'd100, 32'd23, 32'd123, 1'b0);
    wait_out("b2b_0", 1, 1);
    drive(4'd1, 32'd10, 32'd20, 32'hFFFF_FFF6, 1'b0);
    wait_out("b2b_1", 1, 1);
    drive(4'd15, 32'd1, 32'd1, 32'h0, 1'b1);
    wait_out("b2b_2", 1, 1);
    consume();
    check("b2b_idle", out_valid, 1'b0);

    // Configuration without the multiplier
    op_0 = 4'd10; operand_a_0 = 32'd7; operand_b_0 = 32'd9; in_valid_0 = 1'b1;
    @(posedge clk); #1;
    in_valid_0 = 1'b0;
    check("nomul_out_valid", out_valid_0, 1'b1);
    check("nomul_result", result_0, 32'h0);
    check("nomul_illegal", illegal_op_0, 1'b1);
    out_ready_0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("nomul_in_ready", in_ready_0, 1'b1);
    check("nomul_busy_never", busy0_seen, 1'b0);
    out_ready_0 = 1'b0;

    // Reset in the middle of a multiply
    drive(4'd10, 32'd3, 32'd5, 32'd15, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    check("midmul_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midmul_out_valid", out_valid, 1'b0);
    check("midmul_busy", busy, 1'b0);
    check("midmul_in_ready", in_ready, 1'b1);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midmul_still_idle", out_valid, 1'b0);
    run_fast("post_rst_add", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised successor to the single-cycle execute ALU, with XLEN-wide operands and a valid/ready handshake on both input and output. Simple integer ops return a registered result one cycle after acceptance. Unsigned multiply (low and high half) uses an iterative shift-add engine and takes XLEN+1 cycles. The unit sits between decode/register-read and writeback; the load/store path is handled elsewhere.

Parameters:
XLEN, 32, operand/result width; power of two, >= 8.
MUL_EN, 1, 1 = MUL/MULHU implemented; 0 = those opcodes are treated as illegal.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operation presented.
in_ready  output  1  unit can accept an operation this cycle.
op  input  4  opcode: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULHU, 12-15 illegal.
operand_a  input  XLEN  first operand.
operand_b  input  XLEN  second operand; shift ops use only the low log2(XLEN) bits.
out_valid  output  1  result valid.
out_ready  input  1  consumer takes the result.
result  output  XLEN  registered result.
illegal_op  output  1  qualifies result; 1 = illegal opcode.
busy  output  1  multiply iteration in progress.

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, result=0, illegal_op=0, busy=0, all internal registers cleared. Asserting reset during a MUL aborts it and discards the operation.
- States: IDLE, MUL, HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is combinational and never depends on in_valid.
- Accept occurs when in_valid & in_ready. op and operands are captured at accept; later input changes have no effect.
- Fast ops (0-9, illegal codes, and MUL/MULHU when MUL_EN=0):
  - Result is written on the accept edge; next state is HOLD with out_valid=1.
  - Latency is 1 cycle.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLL/SRL are logical shifts; SRA replicates operand_a[XLEN-1].
  - SLT is a two's-complement compare; SLTU is an unsigned compare. Both return 0 or 1, zero-extended.
- Illegal op: result=0, illegal_op=1; otherwise illegal_op=0.
- MUL/MULHU (MUL_EN=1):
  - On accept: state goes to MUL, busy=1, 2*XLEN accumulator cleared, count=0.
  - Each MUL cycle: if operand_b[count], add (operand_a << count) into the accumulator; then count++.
  - After the step with count==XLEN-1, go to HOLD. result = acc[XLEN-1:0] for MUL, acc[2XLEN-1:XLEN] for MULHU.
  - out_valid rises XLEN+1 cycles after the accept edge.
  - in_ready=0 throughout MUL.
- HOLD:
  - out_valid=1; result and illegal_op stay stable while out_ready=0.
  - On out_ready=1: the result is consumed. If an accept happens in the same cycle, the new op proceeds (fast op goes to HOLD with the new result, MUL goes to MUL). Otherwise go to IDLE with out_valid=0.
- out_valid is 0 in IDLE and MUL. busy is 1 only in MUL.
- Back-to-back fast ops with out_ready held at 1 sustain one result per cycle.

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> out_valid=0, result=0, illegal_op=0, busy=0, in_ready=1 after release.
2. Arithmetic, XLEN=32: ADD 0xFFFFFFFF+1 -> 0x00000000; SUB 0-1 -> 0xFFFFFFFF; SRA 0x80000000 by b=0x24 -> 0xF8000000 (shamt 4); SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0. Each result has out_valid exactly 1 cycle after accept.
3. Multiply: MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MULHU same operands -> 0xFFFFFFFE. out_valid 33 cycles after accept; busy=1 and in_ready=0 during the 32 iteration cycles.
4. Backpressure: ADD 5+7 with out_ready=0 for 3 cycles -> result=12 stable, in_ready=0. Raising out_ready together with a new XOR accept gives the XOR result on the next cycle with no bubble.
5. Illegal/config: op=13 -> result=0, illegal_op=1, 1-cycle latency. With MUL_EN=0, op=10 -> result=0, illegal_op=1, busy never asserts.
6. Reset mid-MUL: assert rst_n=0 10 cycles into a MUL -> immediate IDLE, out_valid=0. After release, ADD 2+3 -> 5 with 1-cycle latency.
